// File: rtl/s386_bist_pkg.sv
// s386 BIST shared types and constants.
// Provides state encoding, vector width, LFSR taps and counter width.
package s386_bist_pkg;

  localparam int W     = 7;
  localparam int CNT_W = 10;

  // x^7 + x^6 + 1 feedback taps
  localparam int LFSR_TAP_HI = W - 1;
  localparam int LFSR_TAP_LO = W - 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_RUN,
    ST_COMPARE,
    ST_DONE
  } state_t;

  typedef enum logic {
    MODE_GEN,
    MODE_CMP
  } lm_mode_t;

endpackage

// File: rtl/s386_bist_ctrl_if.sv
// s386 BIST bus: test-manager handshake plus core stimulus/response.
// slave = BIST controller side, master = harness/test-manager side.
interface s386_bist_ctrl_if;
  import s386_bist_pkg::*;

  logic             start;
  logic [W-1:0]     golden_sig;
  logic [W-1:0]     core_out;
  logic [W-1:0]     core_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [W-1:0]     signature;
  logic [CNT_W-1:0] pat_cnt;

  modport master (
    output start, golden_sig, core_out,
    input  core_in, busy, done, pass,
    input  signature, pat_cnt
  );

  modport slave (
    input  start, golden_sig, core_out,
    output core_in, busy, done, pass,
    output signature, pat_cnt
  );

endinterface

// File: rtl/s386_bist_ctrl_lfsr_misr.sv
// Shift register used as pattern LFSR (MODE_GEN) or response MISR (MODE_CMP).
// Ports: CK/RST, i_load (reseed), i_en (shift), i_mode, i_data, o_q.
module bist_lfsr_misr
  import s386_bist_pkg::*;
#(
  parameter int           W      = 7,
  parameter logic [W-1:0] SEED   = '0,
  parameter int           TAP_HI = W - 1,
  parameter int           TAP_LO = W - 2
) (
  input  logic         CK,
  input  logic         RST,
  input  logic         i_load,
  input  logic         i_en,
  input  lm_mode_t     i_mode,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;
  logic [W-1:0] w_next;
  logic [W-1:0] w_inj;

  assign w_inj  = (i_mode == MODE_CMP) ? i_data : '0;
  assign w_next = {r_q[W-2:0], r_q[TAP_HI] ^ r_q[TAP_LO]} ^ w_inj;

  always_ff @(posedge CK) begin
    if (RST)         r_q <= SEED;
    else if (i_load) r_q <= SEED;
    else if (i_en)   r_q <= w_next;
  end

  assign o_q = r_q;

endmodule

// File: rtl/s386_bist_ctrl.sv
// BIST sequencer for the s386 core: LFSR stimulus, MISR compaction, golden compare.
// Ports: CK, RST (sync, active-high), bus (slave side of s386_bist_ctrl_if).
module s386_bist_ctrl
  import s386_bist_pkg::*;
#(
  parameter int unsigned  NUM_PATTERNS = 100,
  parameter int unsigned  FLUSH_CYCLES = 8,
  parameter logic [W-1:0] LFSR_SEED    = 7'h01,
  parameter logic [W-1:0] MISR_SEED    = 7'h00
) (
  input  logic             CK,
  input  logic             RST,
  s386_bist_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] PAT_LAST =
    CNT_W'(NUM_PATTERNS - 1);
  localparam logic [3:0] FL_LAST =
    4'((FLUSH_CYCLES == 0) ? 0 : FLUSH_CYCLES - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [3:0]       r_flush_cnt;
  logic [CNT_W-1:0] r_pat_cnt;
  logic             r_pass;
  logic             w_start;
  logic             w_run;
  logic [W-1:0]     w_lfsr;
  logic [W-1:0]     w_misr;

  assign w_start = (r_state == ST_IDLE) && bus.start;
  assign w_run   = (r_state == ST_RUN);

  always_ff @(posedge CK) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:
        if (bus.start)
          w_next_state = (FLUSH_CYCLES == 0) ? ST_RUN : ST_FLUSH;
      ST_FLUSH:
        if (r_flush_cnt == FL_LAST) w_next_state = ST_RUN;
      ST_RUN:
        if (r_pat_cnt == PAT_LAST) w_next_state = ST_COMPARE;
      ST_COMPARE: w_next_state = ST_DONE;
      ST_DONE:    w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.core_in = '0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    unique case (r_state)
      ST_FLUSH:   bus.busy = 1'b1;
      ST_RUN: begin
        bus.busy    = 1'b1;
        bus.core_in = w_lfsr;
      end
      ST_COMPARE: bus.busy = 1'b1;
      ST_DONE:    bus.done = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      r_flush_cnt <= '0;
      r_pat_cnt   <= '0;
      r_pass      <= 1'b0;
    end else begin
      if (w_start) begin
        r_flush_cnt <= '0;
        r_pat_cnt   <= '0;
        r_pass      <= 1'b0;
      end
      if (r_state == ST_FLUSH)
        r_flush_cnt <= r_flush_cnt + 4'd1;
      if (w_run)
        r_pat_cnt <= r_pat_cnt + 1'b1;
      if (r_state == ST_COMPARE)
        r_pass <= (w_misr == bus.golden_sig);
    end
  end

  bist_lfsr_misr #(
    .W(W), .SEED(LFSR_SEED),
    .TAP_HI(LFSR_TAP_HI), .TAP_LO(LFSR_TAP_LO)
  ) u_lfsr (
    .CK(CK), .RST(RST),
    .i_load(w_start), .i_en(w_run),
    .i_mode(MODE_GEN), .i_data('0),
    .o_q(w_lfsr)
  );

  // core_out is sampled in the same RUN cycle its stimulus is applied
  bist_lfsr_misr #(
    .W(W), .SEED(MISR_SEED),
    .TAP_HI(LFSR_TAP_HI), .TAP_LO(LFSR_TAP_LO)
  ) u_misr (
    .CK(CK), .RST(RST),
    .i_load(w_start), .i_en(w_run),
    .i_mode(MODE_CMP), .i_data(bus.core_out),
    .o_q(w_misr)
  );

  assign bus.signature = w_misr;
  assign bus.pat_cnt   = r_pat_cnt;
  assign bus.pass      = r_pass;

endmodule

// File: tb/tb_s386_bist_ctrl.sv
// Testbench for s386_bist_ctrl: short config (F=0,N=8) and default config
// driven by a random combinational core table, checked against a reference model.
module tb_s386_bist_ctrl;
  import s386_bist_pkg::*;

  localparam int NA = 8;
  localparam int FA = 0;
  localparam int NB = 100;
  localparam int FB = 8;

  logic CK = 1'b0;
  logic RST_A = 1'b1;
  logic RST_B = 1'b1;
  always #5 CK = ~CK;

  s386_bist_ctrl_if ia ();
  s386_bist_ctrl_if ib ();

  s386_bist_ctrl #(
    .NUM_PATTERNS(NA), .FLUSH_CYCLES(FA)
  ) dut_a (
    .CK(CK), .RST(RST_A), .bus(ia.slave)
  );

  s386_bist_ctrl dut_b (
    .CK(CK), .RST(RST_B), .bus(ib.slave)
  );

  logic [6:0] tbl [128];
  bit troj = 1'b0;

  assign ia.core_out = '0;
  assign ib.core_out = tbl[ib.core_in] ^
    ((troj && ib.core_in == 7'h01) ? 7'h10 : 7'h00);

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lstep(int x);
    return ((x << 1) & 127) | (((x >> 6) ^ (x >> 5)) & 1);
  endfunction

  function automatic int model_sig(int n, bit trj);
    int l = 1;
    int s = 0;
    int r;
    for (int i = 0; i < n; i++) begin
      r = int'(tbl[l]) ^ ((trj && l == 1) ? 16 : 0);
      s = lstep(s) ^ r;
      l = lstep(l);
    end
    return s;
  endfunction

  task automatic run_a(int gold, int exp_pass);
    int m = 1;
    ia.golden_sig = 7'(gold);
    ia.start = 1'b1;
    @(posedge CK); #1;
    ia.start = 1'b0;
    for (int j = 0; j < NA; j++) begin
      chk("a_core_in", ia.core_in, m);
      chk("a_run_busy", ia.busy, 1);
      m = lstep(m);
      @(posedge CK); #1;
    end
    chk("a_cmp_busy", ia.busy, 1);
    chk("a_cmp_core_in", ia.core_in, 0);
    chk("a_cmp_done", ia.done, 0);
    @(posedge CK); #1;
    chk("a_done", ia.done, 1);
    chk("a_done_busy", ia.busy, 0);
    chk("a_pat_cnt", ia.pat_cnt, NA);
    chk("a_sig", ia.signature, 0);
    chk("a_pass", ia.pass, exp_pass);
    @(posedge CK); #1;
    chk("a_done_pulse", ia.done, 0);
    chk("a_pass_hold", ia.pass, exp_pass);
  endtask

  task automatic start_b(bit hold);
    ib.start = 1'b1;
    @(posedge CK); #1;
    if (!hold) ib.start = 1'b0;
  endtask

  task automatic run_b(int gold, int exp_sig, int pulse_at, int rst_at);
    int m = 1;
    int ci, pc;
    bit seen;
    for (int j = 0; j <= FB + NB + 2; j++) begin
      ci = (j >= FB && j < FB + NB) ? m : 0;
      pc = (j < FB) ? 0 : ((j < FB + NB) ? j - FB : NB);
      chk("b_core_in", ib.core_in, ci);
      chk("b_busy", ib.busy, (j <= FB + NB) ? 1 : 0);
      chk("b_done", ib.done, (j == FB + NB + 1) ? 1 : 0);
      chk("b_pat_cnt", ib.pat_cnt, pc);
      if (j == 0) chk("b_pass_clr", ib.pass, 0);
      if (j == FB + NB + 1) begin
        chk("b_sig", ib.signature, exp_sig);
        chk("b_pass", ib.pass, (gold == exp_sig) ? 1 : 0);
      end
      if (j == FB + NB + 2)
        chk("b_pass_hold", ib.pass, (gold == exp_sig) ? 1 : 0);
      if (j >= FB && j < FB + NB) m = lstep(m);
      if (rst_at >= 0 && j == FB + rst_at) begin
        RST_B = 1'b1;
        @(posedge CK); #1;
        RST_B = 1'b0;
        chk("b_rst_busy", ib.busy, 0);
        chk("b_rst_core_in", ib.core_in, 0);
        chk("b_rst_pat_cnt", ib.pat_cnt, 0);
        chk("b_rst_sig", ib.signature, 0);
        chk("b_rst_pass", ib.pass, 0);
        seen = 1'b0;
        for (int k = 0; k < NB + FB + 4; k++) begin
          if (ib.done !== 1'b0) seen = 1'b1;
          @(posedge CK); #1;
        end
        chk("b_rst_no_done", seen, 0);
        return;
      end
      if (pulse_at >= 0) ib.start = (j == FB + pulse_at);
      ib.golden_sig = (j == FB + NB) ? 7'(gold) : 7'($urandom);
      if (j < FB + NB + 2) begin
        @(posedge CK); #1;
      end
    end
  endtask

  int clean, trsig;

  initial begin
    ia.start = 1'b0;
    ia.golden_sig = '0;
    ib.start = 1'b0;
    ib.golden_sig = '0;
    for (int i = 0; i < 128; i++) tbl[i] = 7'($urandom);
    repeat (2) @(posedge CK);
    #1;
    chk("rst_a_core_in", ia.core_in, 0);
    chk("rst_a_busy", ia.busy, 0);
    chk("rst_a_done", ia.done, 0);
    chk("rst_a_pass", ia.pass, 0);
    chk("rst_a_sig", ia.signature, 0);
    chk("rst_a_pat_cnt", ia.pat_cnt, 0);
    chk("rst_b_busy", ib.busy, 0);
    chk("rst_b_sig", ib.signature, 0);
    chk("rst_b_pat_cnt", ib.pat_cnt, 0);
    RST_A = 1'b0;
    RST_B = 1'b0;
    @(posedge CK); #1;

    run_a(0, 1);
    repeat (2) @(posedge CK);
    #1;
    run_a(1, 0);

    clean = model_sig(NB, 1'b0);
    trsig = model_sig(NB, 1'b1);

    start_b(1'b0);
    run_b(clean, clean, -1, -1);

    troj = 1'b1;
    start_b(1'b0);
    run_b(clean, trsig, -1, -1);
    troj = 1'b0;

    start_b(1'b0);
    run_b(clean, clean, 40, -1);

    start_b(1'b0);
    run_b(clean, clean, -1, 50);

    start_b(1'b1);
    run_b(clean, clean, -1, -1);
    @(posedge CK); #1;
    ib.start = 1'b0;
    run_b(clean, clean, -1, -1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
